// File: rtl/arb_rr_onehot.sv
// Round-robin arbiter with a registered one-hot grant and matching binary index.
// Priority rotates past each grantee on release or hold expiry; en gates only new grants.
module arb_rr_onehot #(
  parameter int N        = 15,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    idx_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [N-1:0]        gnt_q;
  logic                valid_q;

  logic [IDX_W-1:0]    after_g;
  logic [IDX_W-1:0]    scan_base;
  logic [IDX_W-1:0]    win_idx_d;
  logic                win_found_d;
  logic [N-1:0]        win_gnt_d;
  logic [IDX_W:0]      cand;
  logic                cur_req;
  logic                expired;

  // While granting, the scan always starts just past the current grantee.
  always_comb begin
    after_g   = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
    scan_base = (state_q == GRANT) ? after_g : ptr_q;
    cur_req   = req[idx_q];
    expired   = (hold_q == HOLD_W'(MAX_HOLD - 1));
  end

  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, scan_base} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N)) cand = cand - (IDX_W + 1)'(N);
      if (!win_found_d && req[cand[IDX_W-1:0]]) begin
        win_found_d = 1'b1;
        win_idx_d   = cand[IDX_W-1:0];
      end
    end
    win_gnt_d = {{(N-1){1'b0}}, 1'b1} << win_idx_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en && win_found_d) begin
            gnt_q   <= win_gnt_d;
            idx_q   <= win_idx_d;
            valid_q <= 1'b1;
            hold_q  <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!cur_req || expired) begin
            ptr_q <= after_g;
            if (en && win_found_d) begin
              gnt_q  <= win_gnt_d;
              idx_q  <= win_idx_d;
              hold_q <= '0;
            end else if (!cur_req) begin
              gnt_q   <= '0;
              valid_q <= 1'b0;
              state_q <= IDLE;
            end else begin
              // en=0 at expiry: the grantee keeps the resource for a fresh hold window.
              hold_q <= '0;
            end
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_idx   = idx_q;

endmodule

// File: tb/tb_arb_rr_onehot.sv
// Directed bench for arb_rr_onehot: the driver queues hand-computed expectations,
// a monitor pops one after every rising edge and compares it with the outputs.
module tb_arb_rr_onehot;

  localparam int N = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b1;
  logic [N-1:0]  req = 15'h7FFF;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [3:0]    gnt_idx;

  typedef struct packed {
    logic       v;
    logic [3:0] idx;
    logic [7:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   step_n = 0;

  arb_rr_onehot #(.N(N), .IDX_W(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req_v);
    tests++;
    if (act !== req_v) begin
      fails++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, id, act, req_v);
    end
  endtask

  // Apply inputs for the next rising edge and queue what the outputs must be after it.
  task automatic cyc(input logic e, input logic [N-1:0] r, input logic ev, input logic [3:0] ei);
    exp_t x;
    en  = e;
    req = r;
    x.v   = ev;
    x.idx = ei;
    x.id  = 8'(step_n);
    exp_q.push_back(x);
    step_n++;
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t x;
    logic [N-1:0] eg;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x  = exp_q.pop_front();
        eg = x.v ? (15'h0001 << x.idx) : 15'h0000;
        check("gnt_valid", int'(x.id), 32'(gnt_valid), 32'(x.v));
        check("gnt", int'(x.id), 32'(gnt), 32'(eg));
        check("gnt_idx", int'(x.id), 32'(gnt_idx), 32'(x.idx));
        $display("[TB] step %0d en=%b req=%h -> gnt=%h valid=%b idx=%0d", x.id, en, req, gnt, gnt_valid, gnt_idx);
      end
    end
  end

  initial begin : driver
    #1;
    check("rst_gnt", -1, 32'(gnt), 32'h0);
    check("rst_valid", -1, 32'(gnt_valid), 32'h0);
    check("rst_idx", -1, 32'(gnt_idx), 32'h0);
    @(negedge clk);

    // Reset held with all requests, then first grant goes to 0.
    cyc(1'b1, 15'h7FFF, 1'b0, 4'd0);
    cyc(1'b1, 15'h7FFF, 1'b0, 4'd0);
    rst = 1'b0;
    cyc(1'b1, 15'h7FFF, 1'b1, 4'd0);
    cyc(1'b1, 15'h0000, 1'b0, 4'd0);

    // Single requester 5 for three cycles; ptr ends at 6.
    cyc(1'b1, 15'h0020, 1'b1, 4'd5);
    cyc(1'b1, 15'h0020, 1'b1, 4'd5);
    cyc(1'b1, 15'h0020, 1'b1, 4'd5);
    cyc(1'b1, 15'h0000, 1'b0, 4'd5);

    // From ptr 6: 9 beats 3, then 3 follows with no bubble.
    cyc(1'b1, 15'h0208, 1'b1, 4'd9);
    cyc(1'b1, 15'h0208, 1'b1, 4'd9);
    cyc(1'b1, 15'h0008, 1'b1, 4'd3);
    cyc(1'b1, 15'h0008, 1'b1, 4'd3);
    cyc(1'b1, 15'h0000, 1'b0, 4'd3);

    // Sole requester 14 for ten cycles survives two expiries.
    for (int i = 0; i < 10; i++) cyc(1'b1, 15'h4000, 1'b1, 4'd14);
    cyc(1'b1, 15'h0000, 1'b0, 4'd14);
    cyc(1'b1, 15'h0003, 1'b1, 4'd0);
    cyc(1'b1, 15'h0000, 1'b0, 4'd0);

    // Forced preemption between 2 and 7, four cycles each.
    for (int i = 0; i < 4; i++) cyc(1'b1, 15'h0084, 1'b1, 4'd2);
    for (int i = 0; i < 4; i++) cyc(1'b1, 15'h0084, 1'b1, 4'd7);
    cyc(1'b1, 15'h0084, 1'b1, 4'd2);
    cyc(1'b1, 15'h0084, 1'b1, 4'd2);
    cyc(1'b1, 15'h0000, 1'b0, 4'd2);

    // Enable gating: no new grant while en=0, existing grant renewed past expiry.
    cyc(1'b0, 15'h0010, 1'b0, 4'd2);
    cyc(1'b0, 15'h0010, 1'b0, 4'd2);
    cyc(1'b1, 15'h0010, 1'b1, 4'd4);
    for (int i = 0; i < 5; i++) cyc(1'b0, 15'h0050, 1'b1, 4'd4);

    // Asynchronous reset between edges clears the grant at once.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_gnt", -2, 32'(gnt), 32'h0);
    check("async_valid", -2, 32'(gnt_valid), 32'h0);
    check("async_idx", -2, 32'(gnt_idx), 32'h0);
    @(negedge clk);
    cyc(1'b1, 15'h4002, 1'b0, 4'd0);
    rst = 1'b0;
    cyc(1'b1, 15'h4002, 1'b1, 4'd1);
    cyc(1'b1, 15'h0000, 1'b0, 4'd1);

    begin : drain
      int budget;
      budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        #2;
        budget--;
      end
      tests++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arb_rr_onehot.md
Name: arb_rr_onehot

Overview:
- Round-robin arbiter that shares one downstream resource, such as a one-hot-select datapath, among N requesters.
- Issues a registered one-hot grant plus the matching binary index, so a one-hot encoder stage or mux select can be driven directly.
- Rotating priority pointer, bounded hold time with forced preemption, and a global enable for new grants.

Parameters:
- N, 15, number of requesters (2..2^IDX_W).
- IDX_W, 4, width of the binary grant index.
- MAX_HOLD, 4, maximum consecutive granted cycles before forced re-arbitration (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  when 1, new grants may be issued; an existing grant is never cut by en=0.
- req  input  N  request vector; a requester holds its bit high for as long as it needs the resource.
- gnt  output  N  registered one-hot grant; all zero when no grant.
- gnt_valid  output  1  1 when gnt is non-zero.
- gnt_idx  output  IDX_W  binary index of the granted requester; holds its last value when gnt_valid=0.

Behaviour:
- Reset (async, immediate, no clock needed):
  - Outputs: gnt=0, gnt_valid=0, gnt_idx=0.
  - Internal: ptr=0, hold_cnt=0, state IDLE.
- Invariant: gnt_valid=1 implies gnt == (1 << gnt_idx), with exactly one bit set.
- Arbitration function: scan req starting at ptr, ascending, wrapping N-1 -> 0. The first set bit wins.
- State IDLE:
  - If en=1 and req!=0 at a rising edge, the winner is granted at that edge: gnt, gnt_valid, gnt_idx update, hold_cnt=0, go to GRANT.
  - Latency is 1 cycle from req sampled to gnt visible.
  - en=0, or req=0, means stay in IDLE with outputs at 0.
- State GRANT (grantee g), evaluated at every rising edge:
  - Release, req[g]=0: set ptr=(g+1) mod N and arbitrate using the new ptr.
    - en=1 and a winner exists: grant it at this same edge, with no idle bubble, and hold_cnt=0.
    - Otherwise: gnt=0, gnt_valid=0, go to IDLE.
  - Expiry, req[g]=1 and hold_cnt==MAX_HOLD-1: set ptr=(g+1) mod N and arbitrate.
    - g is last in scan order, so g wins only if it is the sole requester; in that case the grant is renewed and hold_cnt=0.
    - If en=0, the grant to g is renewed and hold_cnt=0.
  - Otherwise: hold_cnt increments and the grant is unchanged.
- Timing consequences:
  - gnt falls one cycle after req[g] falls.
  - No requester holds gnt for more than MAX_HOLD consecutive cycles while another requester is asserted and en=1.
- Requests that appear mid-grant are not considered until the next release or expiry; no preemption occurs otherwise.
- Reset asserted mid-grant clears the grant immediately. After deassertion, arbitration restarts from ptr=0.
- Unused index values (gnt_idx >= N) are never produced.
- hold_cnt width is clog2(MAX_HOLD), minimum 1 bit.

Test Plan:
1. Reset: rst=1 with req=15'h7FFF, en=1 -> gnt=0, gnt_valid=0, gnt_idx=0 throughout; after rst falls, next edge -> gnt=15'h0001, gnt_idx=0.
2. Single request: ptr=0, req[5]=1 for 3 cycles then 0 -> gnt=15'h0020, gnt_idx=5 from the edge after req rises; gnt_valid drops one cycle after req falls; ptr=6.
3. Priority and back-to-back: ptr=6, req[3] and req[9] rise together and each drops after 2 granted cycles -> gnt_idx=9 first, then gnt_idx=3 on the edge that releases 9, with gnt_valid continuously 1.
4. Forced preemption (MAX_HOLD=4): ptr=0, req[2] and req[7] held high -> grant sequence 2,2,2,2,7,7,7,7,2,... with exactly 4 cycles each.
5. Sole requester and wrap: req[14] alone held 10 cycles -> gnt=15'h4000 continuously, gnt_valid never drops; release sets ptr=0; then req[0] and req[1] together -> gnt_idx=0 wins.
6. Enable and async reset: en=0 with req[4]=1 -> no grant; en=1 -> gnt_idx=4; en=0 with req[4] held past 4 cycles and req[6]=1 -> grant stays on 4. Then assert rst between clock edges -> gnt=0 and gnt_valid=0 immediately.
